prog_load_ctrl: RTL and testbench

Boot/program-load controller for the fetch stage. Receives a framed byte stream from the host link, assembles little-endian 32-bit instruction words, writes them into instruction memory through the debug write port, and holds the core stalled until a load completes. After a load it forces the PC to 0 and releases the core. A new frame can be loaded at any time, which re-halts the core.

---
 rtl/prog_load_ctrl_if.sv | 25 ++
 rtl/prog_load_ctrl.sv | 136 +++++++++++++
 tb/tb_prog_load_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/prog_load_ctrl_if.sv
// rtl/prog_load_ctrl_if.sv - host byte link, core control and imem debug write port bundle
interface prog_load_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        core_hold;
  logic        pc_rst;
  logic        dbg_sig;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_instr;
  logic        load_done;
  logic        err;

  // host / fetch-stage side
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, core_hold, pc_rst, dbg_sig, dbg_addr, dbg_instr, load_done, err
  );

  // load controller side
  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, core_hold, pc_rst, dbg_sig, dbg_addr, dbg_instr, load_done, err
  );
endinterface

// File: rtl/prog_load_ctrl.sv
// rtl/prog_load_ctrl.sv - framed byte-stream program loader that holds the core until the image verifies
module prog_load_ctrl #(
  parameter int unsigned WORDS_MAX = 1024,
  parameter logic [7:0]  MAGIC     = 8'hA5
) (
  input logic              clk,
  input logic              nrst,
  prog_load_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, CSUM, RELEASE, RUN
  } state_t;

  localparam logic [16:0] WMAX = 17'(WORDS_MAX);

  state_t      state;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic [31:0] word;

  logic        accept;
  logic        is_magic;
  logic [15:0] len_full;
  logic [15:0] word_idx_inc;

  assign accept       = bus.rx_valid & bus.rx_ready;
  assign is_magic     = (bus.rx_data == MAGIC);
  assign len_full     = {bus.rx_data, n_words[7:0]};
  assign word_idx_inc = word_idx + 16'd1;

  // Frame parser FSM; every output is a register updated on the transition into its state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      n_words       <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      csum          <= '0;
      word          <= '0;
      bus.rx_ready  <= 1'b1;
      bus.core_hold <= 1'b1;
      bus.pc_rst    <= 1'b0;
      bus.dbg_sig   <= 1'b0;
      bus.dbg_addr  <= '0;
      bus.dbg_instr <= '0;
      bus.load_done <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.pc_rst  <= 1'b0;
      bus.dbg_sig <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && is_magic) begin
            state    <= LEN0;
            bus.err  <= 1'b0;
            word_idx <= '0;
            byte_idx <= '0;
            csum     <= '0;
          end
        end
        LEN0: begin
          if (accept) begin
            n_words[7:0] <= bus.rx_data;
            state        <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            n_words[15:8] <= bus.rx_data;
            if ({1'b0, len_full} > WMAX) begin
              bus.err <= 1'b1;
              state   <= IDLE;
            end else if (len_full == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            word[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
            csum     <= csum ^ bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            // Last byte of the word: present the full word to imem in the next cycle
            if (byte_idx == 2'd3) begin
              state         <= WRITE;
              bus.rx_ready  <= 1'b0;
              bus.dbg_sig   <= 1'b1;
              bus.dbg_addr  <= {16'd0, word_idx};
              bus.dbg_instr <= {bus.rx_data, word[23:0]};
            end
          end
        end
        WRITE: begin
          bus.rx_ready <= 1'b1;
          word_idx     <= word_idx_inc;
          state        <= (word_idx_inc == n_words) ? CSUM : DATA;
        end
        CSUM: begin
          if (accept) begin
            if (bus.rx_data == csum) begin
              state      <= RELEASE;
              bus.pc_rst <= 1'b1;
            end else begin
              bus.err <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        RELEASE: begin
          state         <= RUN;
          bus.core_hold <= 1'b0;
          bus.load_done <= 1'b1;
        end
        RUN: begin
          // A new frame re-halts the core before any of its words are written
          if (accept && is_magic) begin
            state         <= LEN0;
            bus.core_hold <= 1'b1;
            bus.load_done <= 1'b0;
            bus.err       <= 1'b0;
            word_idx      <= '0;
            byte_idx      <= '0;
            csum          <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb/tb_prog_load_ctrl.sv - scoreboard bench for prog_load_ctrl
module tb_prog_load_ctrl;

  typedef struct {
    logic        kind;   // 0 = imem write, 1 = pc reset pulse
    logic [31:0] addr;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic nrst;
  int   tests;
  int   fails;
  exp_t exp_q[$];

  prog_load_ctrl_if bus();

  prog_load_ctrl #(.WORDS_MAX(1024), .MAGIC(8'hA5)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = 1'b0; e.addr = a; e.instr = d;
    exp_q.push_back(e);
  endtask

  task automatic push_release();
    exp_t e;
    e.kind = 1'b1; e.addr = '0; e.instr = '0;
    exp_q.push_back(e);
  endtask

  // Present one byte and return #1 after the edge that accepted it
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    while (!bus.rx_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("rx_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[$]);
    foreach (b[i]) send_byte(b[i]);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every dbg_sig or pc_rst cycle must match the next scoreboard entry
  always @(negedge clk) begin
    if (nrst && (bus.dbg_sig || bus.pc_rst)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {31'd0, bus.pc_rst, bus.dbg_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_kind", {63'd0, bus.pc_rst & ~bus.dbg_sig}, {63'd0, e.kind});
        if (!e.kind) begin
          check("dbg_addr", {32'd0, bus.dbg_addr}, {32'd0, e.addr});
          check("dbg_instr", {32'd0, bus.dbg_instr}, {32'd0, e.instr});
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"},  {63'd0, bus.rx_ready},  64'd1);
    check({tag, "_core_hold"}, {63'd0, bus.core_hold}, 64'd1);
    check({tag, "_pc_rst"},    {63'd0, bus.pc_rst},    64'd0);
    check({tag, "_dbg_sig"},   {63'd0, bus.dbg_sig},   64'd0);
    check({tag, "_dbg_addr"},  {32'd0, bus.dbg_addr},  64'd0);
    check({tag, "_dbg_instr"}, {32'd0, bus.dbg_instr}, 64'd0);
    check({tag, "_load_done"}, {63'd0, bus.load_done}, 64'd0);
    check({tag, "_err"},       {63'd0, bus.err},       64'd0);
  endtask

  task automatic good_two_word();
    push_write(32'd0, 32'h0000_0013);
    push_write(32'd1, 32'h0010_0093);
    push_release();
    send_bytes('{8'hA5, 8'h02, 8'h00});
    send_bytes('{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00});
    send_byte(8'h90);
    check("release_hold", {63'd0, bus.core_hold}, 64'd1);
    check("release_pc_rst", {63'd0, bus.pc_rst}, 64'd1);
    idle_cycles(1);
    check("run_hold", {63'd0, bus.core_hold}, 64'd0);
    check("run_done", {63'd0, bus.load_done}, 64'd1);
    check("run_err", {63'd0, bus.err}, 64'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    nrst = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle_cycles(2);
    check_reset_outputs("reset");
    @(negedge clk);
    nrst = 1'b1;
    idle_cycles(2);
    check_reset_outputs("post_reset");

    // Good two-word load
    good_two_word();

    // Non-MAGIC byte in RUN is ignored
    send_byte(8'h13);
    idle_cycles(1);
    check("run_ignore_hold", {63'd0, bus.core_hold}, 64'd0);
    check("run_ignore_done", {63'd0, bus.load_done}, 64'd1);

    // Reload while running, then bad checksum
    send_byte(8'hA5);
    check("reload_hold", {63'd0, bus.core_hold}, 64'd1);
    check("reload_done", {63'd0, bus.load_done}, 64'd0);
    push_write(32'd0, 32'h0000_0013);
    push_write(32'd1, 32'h0010_0093);
    send_bytes('{8'h02, 8'h00});
    send_bytes('{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00});
    send_byte(8'h91);
    check("badcs_err", {63'd0, bus.err}, 64'd1);
    check("badcs_hold", {63'd0, bus.core_hold}, 64'd1);
    idle_cycles(3);
    check("badcs_err_sticky", {63'd0, bus.err}, 64'd1);
    check("badcs_done", {63'd0, bus.load_done}, 64'd0);

    // Good one-word frame clears err and releases
    send_byte(8'hA5);
    check("magic_clears_err", {63'd0, bus.err}, 64'd0);
    push_write(32'd0, 32'hDEAD_BEEF);
    push_release();
    send_bytes('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22});
    idle_cycles(1);
    check("one_word_hold", {63'd0, bus.core_hold}, 64'd0);
    check("one_word_done", {63'd0, bus.load_done}, 64'd1);

    // Empty frame: release without any write
    push_release();
    send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00});
    idle_cycles(1);
    check("empty_hold", {63'd0, bus.core_hold}, 64'd0);
    check("empty_done", {63'd0, bus.load_done}, 64'd1);

    // Oversize frame: N = WORDS_MAX + 1 = 0x0401
    send_bytes('{8'hA5, 8'h01, 8'h04});
    check("oversize_err", {63'd0, bus.err}, 64'd1);
    check("oversize_hold", {63'd0, bus.core_hold}, 64'd1);
    send_bytes('{8'h00, 8'h00, 8'h00, 8'h00});
    idle_cycles(2);
    check("oversize_idle_err", {63'd0, bus.err}, 64'd1);

    // Reset mid-frame after 5 data bytes
    push_write(32'd0, 32'h4433_2211);
    send_bytes('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    #2;
    nrst = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    @(negedge clk);
    nrst = 1'b1;
    idle_cycles(1);
    good_two_word();

    idle_cycles(3);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
